// File: rtl/prism_sp_unit_dispatch_pkg.sv
// Shared types and constants for the SP custom-instruction dispatcher.
package prism_sp_config;

  // Width of the saturating timeout event counter
  localparam int SP_DISP_TIMEOUT_W = 16;

  // Dispatcher states: waiting for a command, waiting for a subunit, holding a writeback
  typedef enum logic [1:0] {
    SP_DISP_IDLE = 2'd0,
    SP_DISP_EXEC = 2'd1,
    SP_DISP_WB   = 2'd2
  } sp_disp_state_t;

endpackage

// File: rtl/prism_sp_unit_dispatch_cmd_decoder.sv
// Splits fn7 into a group/command pair and produces the one-hot command strobe.
// The strobe index equals the low CB+GB bits of fn7 because strobes are group-major.
module prism_sp_cmd_decoder #(
  parameter int NGROUPS        = 4,
  parameter int CMDS_PER_GROUP = 8,
  localparam int GB            = $clog2(NGROUPS),
  localparam int GW            = (GB > 0) ? GB : 1
) (
  input  logic [6:0]                          fn7,
  input  logic                                accept,
  output logic [NGROUPS*CMDS_PER_GROUP-1:0]   cmd_strobe,
  output logic                                illegal,
  output logic [GW-1:0]                       grp
);

  localparam int CB   = $clog2(CMDS_PER_GROUP);
  localparam int NCMD = NGROUPS * CMDS_PER_GROUP;

  logic [6:0] grp_field;
  logic [6:0] slot;

  // Everything above the command bits is the group; any value past the last group
  // (including stray high fn7 bits) is undecodable
  assign grp_field = fn7 >> CB;
  assign slot      = fn7 & 7'(NCMD - 1);
  assign grp       = grp_field[GW-1:0];

  // Raise exactly one strobe, and only while the command is actually being accepted
  always_comb begin
    cmd_strobe = '0;
    illegal    = (grp_field >= 7'(NGROUPS));
    if (accept && !illegal) begin
      cmd_strobe = NCMD'(1) << slot;
    end
  end

endmodule

// File: rtl/prism_sp_unit_dispatch.sv
// Issue/writeback front end for the SP unit: decodes fn7 into subunit command strobes,
// tracks one in-flight command, registers its result and guards it with a watchdog.
module prism_sp_unit_dispatch
  import prism_sp_config::*;
#(
  parameter int                       NGROUPS        = 4,
  parameter int                       CMDS_PER_GROUP = 8,
  parameter int                       RESULT_WIDTH   = 32,
  parameter int                       ID_WIDTH       = 3,
  parameter int                       TIMEOUT_CYCLES = 1024,
  parameter logic [RESULT_WIDTH-1:0]  TIMEOUT_RESULT = '1,
  parameter logic [RESULT_WIDTH-1:0]  ILLEGAL_RESULT = '1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                issue_new_request,
  input  logic [ID_WIDTH-1:0]                 issue_id,
  input  logic [6:0]                          issue_fn7,
  output logic                                issue_ready,
  output logic [NGROUPS*CMDS_PER_GROUP-1:0]   sub_issue_cmd,
  input  logic [NGROUPS-1:0]                  sub_busy,
  input  logic [NGROUPS-1:0]                  sub_done,
  input  logic [NGROUPS*RESULT_WIDTH-1:0]     sub_result,
  output logic                                wb_done,
  output logic [ID_WIDTH-1:0]                 wb_id,
  output logic [RESULT_WIDTH-1:0]             wb_rd,
  input  logic                                wb_ack,
  output logic                                timeout_evt,
  output logic [SP_DISP_TIMEOUT_W-1:0]        timeout_count
);

  localparam int CB      = $clog2(CMDS_PER_GROUP);
  localparam int GB      = $clog2(NGROUPS);
  localparam int GW      = (GB > 0) ? GB : 1;
  localparam int WDW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  if (CB + GB > 7) begin : g_bad_cfg
    $error("prism_sp_unit_dispatch: group and command fields do not fit in fn7");
  end

  sp_disp_state_t         state;
  sp_disp_state_t         next_state;
  logic                   accept;
  logic                   dec_illegal;
  logic [GW-1:0]          dec_grp;
  logic [GW-1:0]          cur_grp;
  logic [WDW-1:0]         wdog;
  logic                   done_cur;
  logic                   expire;
  logic [RESULT_WIDTH-1:0] cur_result;

  assign issue_ready = (state == SP_DISP_IDLE) && !(|sub_busy);
  assign accept      = issue_new_request && issue_ready;

  prism_sp_cmd_decoder #(
    .NGROUPS        (NGROUPS),
    .CMDS_PER_GROUP (CMDS_PER_GROUP)
  ) u_decoder (
    .fn7        (issue_fn7),
    .accept     (accept),
    .cmd_strobe (sub_issue_cmd),
    .illegal    (dec_illegal),
    .grp        (dec_grp)
  );

  // Only the group that owns the in-flight command may complete it
  assign done_cur   = |(sub_done & (NGROUPS'(1) << cur_grp));
  assign cur_result = sub_result[int'(cur_grp)*RESULT_WIDTH +: RESULT_WIDTH];
  assign expire     = (TIMEOUT_CYCLES != 0) && (wdog == WDW'(WD_LAST));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SP_DISP_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe outputs; a done arriving with watchdog expiry takes priority
  always_comb begin
    next_state  = state;
    wb_done     = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      SP_DISP_IDLE: begin
        if (accept) begin
          next_state = dec_illegal ? SP_DISP_WB : SP_DISP_EXEC;
        end
      end
      SP_DISP_EXEC: begin
        if (done_cur) begin
          next_state = SP_DISP_WB;
        end else if (expire) begin
          timeout_evt = 1'b1;
          next_state  = SP_DISP_WB;
        end
      end
      SP_DISP_WB: begin
        wb_done = 1'b1;
        if (wb_ack) begin
          next_state = SP_DISP_IDLE;
        end
      end
      default: next_state = SP_DISP_IDLE;
    endcase
  end

  // Command bookkeeping: id/group capture, watchdog, result capture and timeout counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_grp       <= '0;
      wdog          <= '0;
      wb_id         <= '0;
      wb_rd         <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        SP_DISP_IDLE: begin
          if (accept) begin
            wb_id <= issue_id;
            if (dec_illegal) begin
              wb_rd <= ILLEGAL_RESULT;
            end else begin
              cur_grp <= dec_grp;
              wdog    <= '0;
            end
          end
        end
        SP_DISP_EXEC: begin
          wdog <= wdog + WDW'(1);
          if (done_cur) begin
            wb_rd <= cur_result;
          end else if (expire) begin
            wb_rd <= TIMEOUT_RESULT;
            if (timeout_count != '1) begin
              timeout_count <= timeout_count + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prism_sp_unit_dispatch.sv
// Self-checking bench for prism_sp_unit_dispatch: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a transaction model.
module tb_prism_sp_unit_dispatch;

  localparam int NG  = 4;
  localparam int CPG = 8;
  localparam int RW  = 32;
  localparam int IW  = 3;
  localparam int TC  = 8;
  localparam logic [31:0] TRES = 32'hDEADBEEF;
  localparam logic [31:0] IRES = 32'hBADC0DE1;

  logic            clk;
  logic            rst;
  logic            issue_new_request;
  logic [IW-1:0]   issue_id;
  logic [6:0]      issue_fn7;
  logic            issue_ready;
  logic [NG*CPG-1:0] sub_issue_cmd;
  logic [NG-1:0]   sub_busy;
  logic [NG-1:0]   sub_done;
  logic [NG*RW-1:0] sub_result;
  logic            wb_done;
  logic [IW-1:0]   wb_id;
  logic [RW-1:0]   wb_rd;
  logic            wb_ack;
  logic            timeout_evt;
  logic [15:0]     timeout_count;

  int n_vec = 0;
  int n_err = 0;

  prism_sp_unit_dispatch #(
    .NGROUPS        (NG),
    .CMDS_PER_GROUP (CPG),
    .RESULT_WIDTH   (RW),
    .ID_WIDTH       (IW),
    .TIMEOUT_CYCLES (TC),
    .TIMEOUT_RESULT (TRES),
    .ILLEGAL_RESULT (IRES)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .issue_new_request (issue_new_request),
    .issue_id          (issue_id),
    .issue_fn7         (issue_fn7),
    .issue_ready       (issue_ready),
    .sub_issue_cmd     (sub_issue_cmd),
    .sub_busy          (sub_busy),
    .sub_done          (sub_done),
    .sub_result        (sub_result),
    .wb_done           (wb_done),
    .wb_id             (wb_id),
    .wb_rd             (wb_rd),
    .wb_ack            (wb_ack),
    .timeout_evt       (timeout_evt),
    .timeout_count     (timeout_count)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit req, input logic [IW-1:0] id, input logic [6:0] fn7,
                               input logic [NG-1:0] busy, input logic [NG-1:0] done,
                               input logic [NG*RW-1:0] result, input bit ack);
    issue_new_request = req;
    issue_id          = id;
    issue_fn7         = fn7;
    sub_busy          = busy;
    sub_done          = done;
    sub_result        = result;
    wb_ack            = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: one command may be outstanding, one result may await acknowledge
  bit           m_cmd;
  int           m_grp;
  int           m_age;
  bit           m_wb;
  logic [IW-1:0] m_id;
  logic [RW-1:0] m_rd;
  int           m_tcount;

  // Every negedge: predict outputs from the model and current inputs, compare, then advance
  always @(negedge clk) begin
    bit            exp_ready;
    bit            acc;
    int            hi;
    bit            legal;
    logic [NG*CPG-1:0] exp_strobe;
    bit            d;
    bit            e;
    if (rst) begin
      m_cmd = 0; m_grp = 0; m_age = 0; m_wb = 0; m_id = '0; m_rd = '0; m_tcount = 0;
      checkOutput("rst_wb_done", 64'(wb_done), 64'd0);
      checkOutput("rst_timeout_evt", 64'(timeout_evt), 64'd0);
      checkOutput("rst_timeout_count", 64'(timeout_count), 64'd0);
      checkOutput("rst_wb_id", 64'(wb_id), 64'd0);
      checkOutput("rst_wb_rd", 64'(wb_rd), 64'd0);
    end else begin
      exp_ready  = !m_cmd && !m_wb && (sub_busy == '0);
      acc        = issue_new_request && exp_ready;
      hi         = int'(issue_fn7) / CPG;
      legal      = (hi < NG);
      exp_strobe = '0;
      if (acc && legal) exp_strobe = (NG*CPG)'(1) << (hi * CPG + int'(issue_fn7) % CPG);
      d = m_cmd && sub_done[m_grp];
      e = m_cmd && !d && (m_age == TC - 1);

      checkOutput("model_issue_ready", 64'(issue_ready), 64'(exp_ready));
      checkOutput("model_sub_issue_cmd", 64'(sub_issue_cmd), 64'(exp_strobe));
      checkOutput("model_wb_done", 64'(wb_done), 64'(m_wb));
      checkOutput("model_timeout_evt", 64'(timeout_evt), 64'(e));
      checkOutput("model_timeout_count", 64'(timeout_count), 64'(m_tcount));
      if (m_wb) begin
        checkOutput("model_wb_id", 64'(wb_id), 64'(m_id));
        checkOutput("model_wb_rd", 64'(wb_rd), 64'(m_rd));
      end

      if (m_wb && wb_ack) m_wb = 0;
      if (m_cmd) begin
        if (d) begin
          m_rd = sub_result[m_grp*RW +: RW];
          m_wb = 1; m_cmd = 0;
        end else if (e) begin
          m_rd = TRES;
          if (m_tcount < 16'hFFFF) m_tcount++;
          m_wb = 1; m_cmd = 0;
        end else begin
          m_age++;
        end
      end
      if (acc) begin
        m_id = issue_id;
        if (legal) begin
          m_cmd = 1; m_grp = hi; m_age = 0;
        end else begin
          m_wb = 1; m_rd = IRES;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, '0, '0, '0, '0, '0, 0);
    step();
    checkOutput("reset_wb_done", 64'(wb_done), 64'd0);
    checkOutput("reset_wb_rd", 64'(wb_rd), 64'd0);
    checkOutput("reset_timeout_count", 64'(timeout_count), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Legal command 0x0A: group 1 command 2, done three edges after accept
    applyStimulus(1, 3'd5, 7'h0A, '0, '0, '0, 0);
    #1;
    checkOutput("seq1_strobe_bit10", 64'(sub_issue_cmd), 64'h400);
    checkOutput("seq1_ready", 64'(issue_ready), 64'd1);
    step();
    applyStimulus(0, '0, '0, '0, '0, '0, 0);
    #1;
    checkOutput("seq1_strobe_gone", 64'(sub_issue_cmd), 64'd0);
    checkOutput("seq1_busy_not_ready", 64'(issue_ready), 64'd0);
    step();
    step();
    applyStimulus(0, '0, '0, '0, 4'b0010, {32'h0, 32'h0, 32'h0000CAFE, 32'h0}, 0);
    step();
    applyStimulus(0, '0, '0, '0, '0, '0, 0);
    checkOutput("seq1_wb_done", 64'(wb_done), 64'd1);
    checkOutput("seq1_wb_id", 64'(wb_id), 64'd5);
    checkOutput("seq1_wb_rd", 64'(wb_rd), 64'hCAFE);
    applyStimulus(0, '0, '0, '0, '0, '0, 1);
    step();
    applyStimulus(0, '0, '0, '0, '0, '0, 0);
    checkOutput("seq1_ack_wb_done", 64'(wb_done), 64'd0);

    // Busy subunit blocks acceptance; dropping busy lets the request in
    applyStimulus(1, 3'd2, 7'h01, 4'b0100, '0, '0, 0);
    #1;
    checkOutput("seq2_busy_ready", 64'(issue_ready), 64'd0);
    checkOutput("seq2_busy_strobe", 64'(sub_issue_cmd), 64'd0);
    step();
    applyStimulus(1, 3'd2, 7'h01, 4'b0000, '0, '0, 0);
    #1;
    checkOutput("seq2_free_ready", 64'(issue_ready), 64'd1);
    checkOutput("seq2_free_strobe", 64'(sub_issue_cmd), 64'h2);
    step();
    applyStimulus(0, '0, '0, '0, 4'b0001, {96'h0, 32'h1234}, 0);
    step();
    applyStimulus(0, '0, '0, '0, '0, '0, 1);
    checkOutput("seq2_wb_rd", 64'(wb_rd), 64'h1234);
    step();

    // Watchdog: no done for group 3, expiry on the 8th exec cycle, late done ignored
    applyStimulus(1, 3'd3, 7'h18, '0, '0, '0, 0);
    step();
    applyStimulus(0, '0, '0, '0, '0, '0, 0);
    repeat (6) step();
    checkOutput("seq3_no_early_timeout", 64'(timeout_evt), 64'd0);
    step();
    checkOutput("seq3_timeout_evt", 64'(timeout_evt), 64'd1);
    step();
    checkOutput("seq3_timeout_wb_done", 64'(wb_done), 64'd1);
    checkOutput("seq3_timeout_rd", 64'(wb_rd), 64'(TRES));
    checkOutput("seq3_timeout_count", 64'(timeout_count), 64'd1);
    applyStimulus(0, '0, '0, '0, 4'b1000, {32'h5555, 96'h0}, 0);
    step();
    applyStimulus(0, '0, '0, '0, '0, '0, 1);
    checkOutput("seq3_late_done_ignored", 64'(wb_rd), 64'(TRES));
    step();

    // Undecodable group, writeback held for five cycles with a stray done on group 0
    applyStimulus(1, 3'd6, 7'h20, '0, '0, '0, 0);
    #1;
    checkOutput("seq4_illegal_no_strobe", 64'(sub_issue_cmd), 64'd0);
    step();
    applyStimulus(0, '0, '0, '0, '0, '0, 0);
    checkOutput("seq4_illegal_wb_done", 64'(wb_done), 64'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 3'd1, 7'h02, '0, (i == 2) ? 4'b0001 : 4'b0000, {96'h0, 32'h9999}, 0);
      step();
    end
    checkOutput("seq4_hold_wb_done", 64'(wb_done), 64'd1);
    checkOutput("seq4_hold_wb_id", 64'(wb_id), 64'd6);
    checkOutput("seq4_hold_wb_rd", 64'(wb_rd), 64'(IRES));
    checkOutput("seq4_hold_ready", 64'(issue_ready), 64'd0);
    applyStimulus(0, '0, '0, '0, '0, '0, 1);
    step();

    // Done arriving in the expiry cycle wins over the watchdog
    applyStimulus(1, 3'd4, 7'h11, '0, '0, '0, 0);
    step();
    applyStimulus(0, '0, '0, '0, '0, '0, 0);
    repeat (7) step();
    applyStimulus(0, '0, '0, '0, 4'b0100, {32'h0, 32'h77, 64'h0}, 0);
    #1;
    checkOutput("seq5_coincident_no_evt", 64'(timeout_evt), 64'd0);
    step();
    applyStimulus(0, '0, '0, '0, '0, '0, 1);
    checkOutput("seq5_coincident_rd", 64'(wb_rd), 64'h77);
    checkOutput("seq5_count_unchanged", 64'(timeout_count), 64'd1);
    step();

    // Asynchronous reset in the middle of a command, then a clean command
    applyStimulus(1, 3'd1, 7'h09, '0, '0, '0, 0);
    step();
    applyStimulus(0, '0, '0, '0, '0, '0, 0);
    step();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("seq6_rst_wb_done", 64'(wb_done), 64'd0);
    checkOutput("seq6_rst_count", 64'(timeout_count), 64'd0);
    checkOutput("seq6_rst_ready", 64'(issue_ready), 64'd1);
    step();
    rst = 1'b0;
    applyStimulus(1, 3'd7, 7'h0F, '0, '0, '0, 0);
    #1;
    checkOutput("seq6_post_strobe", 64'(sub_issue_cmd), 64'h8000);
    step();
    applyStimulus(0, '0, '0, '0, 4'b0010, {32'h0, 32'h0, 32'hABCD, 32'h0}, 0);
    step();
    applyStimulus(0, '0, '0, '0, '0, '0, 1);
    checkOutput("seq6_post_wb_id", 64'(wb_id), 64'd7);
    checkOutput("seq6_post_wb_rd", 64'(wb_rd), 64'hABCD);
    step();

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 2000; n++) begin
      logic [6:0]      f;
      logic [NG-1:0]   b;
      logic [NG-1:0]   dn;
      logic [NG*RW-1:0] r;
      f  = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 31)) : 7'($urandom_range(0, 127));
      b  = ($urandom_range(0, 9) == 0) ? NG'($urandom) : '0;
      dn = ($urandom_range(0, 3) == 0) ? NG'($urandom) : '0;
      r  = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), IW'($urandom), f, b, dn, r,
                    ($urandom_range(0, 9) < 4));
      step();
    end

    applyStimulus(0, '0, '0, '0, '0, '0, 0);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
